// File: rtl/uctl_reset_ctrl.sv
// USB controller reset sequencer.
// Sequences PHY, core and SIE resets from POR, soft and bus resets.
module uctl_reset_ctrl #(
   parameter int PHY_HOLD  = 16,
   parameter int LOCK_TO   = 1024,
   parameter int CORE_DLY  = 8,
   parameter int SOFT_HOLD = 8,
   parameter int BUS_HOLD  = 4,
   parameter int CNT_W     = 11
) (
   input  logic       clk,
   input  logic       uctl_PoRst_n,
   input  logic       sync_rst_n,
   input  logic       soft_rst_req,
   input  logic       usb_bus_rst,
   input  logic       phy_pll_lock,
   output logic       phy_rst_n,
   output logic       core_rst_n,
   output logic       sie_rst_n,
   output logic       rst_busy,
   output logic       lock_err,
   output logic [1:0] rst_cause
);

   typedef enum logic [2:0] {
      S_POR,
      S_PHY_WAIT,
      S_CORE_DLY,
      S_RUN,
      S_SOFT,
      S_BUS
   } state_e;

   localparam logic [CNT_W-1:0] PHY_LAST  = CNT_W'(PHY_HOLD - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO - 1);
   localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DLY - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_HOLD - 1);
   localparam logic [CNT_W-1:0] BUS_LAST  = CNT_W'(BUS_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phy_q, phy_d;
   logic             core_q, core_d;
   logic             sie_q, sie_d;
   logic             busy_q, busy_d;
   logic             lock_err_q, lock_err_d;
   logic [1:0]       cause_q, cause_d;
   // seq_soft_q remembers whether the running core sequence came from a soft reset
   logic             seq_soft_q, seq_soft_d;

   // Next-state, counter and reset-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      phy_d      = phy_q;
      core_d     = core_q;
      sie_d      = sie_q;
      lock_err_d = lock_err_q;
      cause_d    = cause_q;
      seq_soft_d = seq_soft_q;
      if (!sync_rst_n) begin
         state_d = S_POR;
         cnt_d   = '0;
         phy_d   = 1'b0;
         core_d  = 1'b0;
         sie_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_POR: begin
               if (cnt_q == PHY_LAST) begin
                  phy_d      = 1'b1;
                  cnt_d      = '0;
                  seq_soft_d = 1'b0;
                  state_d    = S_PHY_WAIT;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_PHY_WAIT: begin
               if (phy_pll_lock) begin
                  cnt_d   = '0;
                  state_d = S_CORE_DLY;
               end else if (cnt_q == LOCK_LAST) begin
                  lock_err_d = 1'b1;
                  cnt_d      = '0;
                  state_d    = S_CORE_DLY;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_CORE_DLY: begin
               if (cnt_q == CORE_LAST) begin
                  core_d  = 1'b1;
                  sie_d   = 1'b1;
                  cnt_d   = '0;
                  cause_d = seq_soft_q ? 2'b01 : 2'b00;
                  state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_RUN: begin
               if (soft_rst_req) begin
                  core_d  = 1'b0;
                  sie_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_SOFT;
               end else if (usb_bus_rst) begin
                  sie_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_BUS;
               end
            end
            S_SOFT: begin
               if (cnt_q == SOFT_LAST) begin
                  cnt_d      = '0;
                  seq_soft_d = 1'b1;
                  state_d    = S_CORE_DLY;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_BUS: begin
               if (soft_rst_req) begin
                  core_d  = 1'b0;
                  sie_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_SOFT;
               end else if (cnt_q == BUS_LAST) begin
                  if (!usb_bus_rst) begin
                     sie_d   = 1'b1;
                     cnt_d   = '0;
                     cause_d = 2'b10;
                     state_d = S_RUN;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_POR;
               cnt_d   = '0;
               phy_d   = 1'b0;
               core_d  = 1'b0;
               sie_d   = 1'b0;
            end
         endcase
      end
      busy_d = (state_d != S_RUN);
   end

   // State and output registers, cleared by the power-on reset
   always_ff @(posedge clk or negedge uctl_PoRst_n) begin
      if (!uctl_PoRst_n) begin
         state_q    <= S_POR;
         cnt_q      <= '0;
         phy_q      <= 1'b0;
         core_q     <= 1'b0;
         sie_q      <= 1'b0;
         busy_q     <= 1'b1;
         lock_err_q <= 1'b0;
         cause_q    <= 2'b00;
         seq_soft_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phy_q      <= phy_d;
         core_q     <= core_d;
         sie_q      <= sie_d;
         busy_q     <= busy_d;
         lock_err_q <= lock_err_d;
         cause_q    <= cause_d;
         seq_soft_q <= seq_soft_d;
      end
   end

   assign phy_rst_n  = phy_q;
   assign core_rst_n = core_q;
   assign sie_rst_n  = sie_q;
   assign rst_busy   = busy_q;
   assign lock_err   = lock_err_q;
   assign rst_cause  = cause_q;

endmodule
